a5_1_keystream_ctrl: RTL
========================

Name: a5_1_keystream_ctrl

Overview:
Sequencer and keystream collector for the A5/1 cipher core, placed between the key/frame source and the three LFSR stages (X, Y, Z).
- Upstream role: clears the registers, serially injects key then frame bits, and runs the warm-up.
- Run phase: applies majority-rule stepping and packs the XOR of the three register MSBs into bytes.
- Downstream role: hands those bytes to the image-encrypt XOR stage over a valid/ready handshake.

Parameters:
- KEY_LEN, 64, number of key bits injected, LSB first.
- FRAME_LEN, 22, number of frame-number bits injected, LSB first.
- WARMUP_LEN, 100, majority-clocked steps whose output is discarded.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a session; ignored while busy=1.
- stop  in  1  one-cycle pulse that ends the RUN state and returns to IDLE.
- key  in  64  session key, sampled on the accepted start.
- frame  in  22  frame number, sampled on the accepted start.
- x_out, y_out, z_out  in  1 each  register MSBs (X bit 18, Y bit 21, Z bit 22).
- x_maj, y_maj, z_maj  in  1 each  register clocking bits (X bit 8, Y bit 10, Z bit 10).
- reg_clear  out  1  drives the registers' reset input.
- shift_bit  out  1  serial bit shared by all three registers.
- x_trigger, y_trigger, z_trigger  out  1 each  per-register step enables.
- ks_byte  out  8  packed keystream byte; first captured bit is in bit 7.
- ks_valid  out  1  ks_byte holds a valid byte.
- ks_ready  in  1  downstream accepts the byte when ks_valid and ks_ready are both 1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. The bit counter, byte shift register and step flag are cleared. Reset mid-session aborts immediately; registered start/stop pulses are lost.
- States: IDLE -> CLEAR -> LOAD_KEY -> LOAD_FRAME -> WARMUP -> RUN -> IDLE.
- IDLE: triggers are 0. On start, latch key and frame, set busy, go to CLEAR.
- CLEAR: lasts 1 cycle with reg_clear=1 and triggers 0.
- LOAD_KEY: lasts KEY_LEN cycles. All triggers are 1; shift_bit=key[i] in the i-th cycle, i=0..KEY_LEN-1.
- LOAD_FRAME: lasts FRAME_LEN cycles. All triggers are 1; shift_bit=frame[j] in the j-th cycle.
- WARMUP: lasts WARMUP_LEN cycles with shift_bit=0 and majority stepping.
  - Majority: m = (x_maj&y_maj)|(x_maj&z_maj)|(y_maj&z_maj).
  - Each register's trigger is 1 when its maj bit equals m, so at least two registers step every cycle.
- RUN, stepping: shift_bit=0 and majority stepping as in WARMUP.
- RUN, capture: in the cycle after each RUN step, ks_bit = x_out^y_out^z_out is shifted into the byte shift register, MSB first. The first captured bit therefore reflects the state after WARMUP_LEN+1 steps.
- RUN, byte completion: after the 8th captured bit, ks_byte is loaded and ks_valid rises the next cycle.
- Stall: the block steps in a cycle only if no completed byte is pending (ks_valid=0, or ks_valid&ks_ready in that cycle). While stalled, all triggers are 0, and ks_byte and ks_valid hold.
- Back-to-back bytes: with ks_ready held at 1, a byte is produced every 8 cycles with no gaps.
- stop: finishes the current cycle and goes to IDLE; busy falls the next cycle. A partial byte is discarded. A pending ks_valid byte stays presented until accepted, and no new steps occur.
- Simultaneous start and stop in IDLE: start wins.
- A start pulse while busy=1 is ignored.
- Counters are 7 bits wide. Each counter compares against its parameter minus 1 and then resets to 0 on the state change.
- Latency from an accepted start to the first ks_valid:
  - 1 + KEY_LEN + FRAME_LEN + WARMUP_LEN + 8 step cycles + 1 cycle.
  - With default parameters that is 196 cycles, assuming no stall.

Test Plan:
- Reset, then hold for 10 cycles -> busy, ks_valid, reg_clear and all triggers stay 0; ks_byte=8'h00.
- start with key=64'h1, frame=0 -> reg_clear=1 for exactly 1 cycle, then 86 cycles with all triggers=1; shift_bit=1 only in the first LOAD_KEY cycle; WARMUP begins at cycle 88.
- In WARMUP, force x_maj=1, y_maj=0, z_maj=1 -> x_trigger=1, y_trigger=0, z_trigger=1. Force all three maj bits to 0 -> all triggers=1.
- Drive x_out=1, y_out=0, z_out=0 with ks_ready=1 -> ks_byte=8'hFF every 8 cycles; first ks_valid 196 cycles after start.
- Hold ks_ready=0 for 5 cycles with ks_valid=1 -> triggers all 0 and ks_byte stable; on acceptance, stepping resumes in that cycle.
- Connect real X/Y/Z registers with key=64'h12_23_45_67_89_AB_CD_EF, frame=22'h134 -> the first 28 bytes match the golden A5/1 software model. Pulse stop and reset mid-RUN -> IDLE and busy=0 the next cycle; a new start gives an identical stream.

Source files
------------

// File: rtl/a5_1_keystream_ctrl.sv
// a5_1_keystream_ctrl: sequencer and keystream collector for an A5/1 cipher core.
//
// The block clears the three external LFSRs (X, Y, Z), serially injects the session key and
// frame number (LSB first), runs the majority-clocked warm-up, then steps the registers under
// the majority rule. It packs the XOR of the register MSBs into bytes (first bit in bit 7) and
// offers them downstream on a valid/ready handshake.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   start, stop            session start pulse (ignored while busy), RUN stop pulse
//   key, frame             session key and frame number, captured on the accepted start
//   x_out, y_out, z_out    register MSBs (X[18], Y[21], Z[22])
//   x_maj, y_maj, z_maj    register clocking bits (X[8], Y[10], Z[10])
//   reg_clear              clears the registers
//   shift_bit              serial input bit shared by all three registers
//   x/y/z_trigger          per-register step enables
//   ks_byte, ks_valid      keystream byte and its valid flag
//   ks_ready               downstream accept
//   busy                   high in every state except IDLE
module a5_1_keystream_ctrl #(
    parameter int unsigned KEY_LEN    = 64,
    parameter int unsigned FRAME_LEN  = 22,
    parameter int unsigned WARMUP_LEN = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [KEY_LEN-1:0]   key,
    input  logic [FRAME_LEN-1:0] frame,
    input  logic                 x_out,
    input  logic                 y_out,
    input  logic                 z_out,
    input  logic                 x_maj,
    input  logic                 y_maj,
    input  logic                 z_maj,
    output logic                 reg_clear,
    output logic                 shift_bit,
    output logic                 x_trigger,
    output logic                 y_trigger,
    output logic                 z_trigger,
    output logic [7:0]           ks_byte,
    output logic                 ks_valid,
    input  logic                 ks_ready,
    output logic                 busy
);

    localparam logic [6:0] KeyLast    = 7'(KEY_LEN - 1);
    localparam logic [6:0] FrameLast  = 7'(FRAME_LEN - 1);
    localparam logic [6:0] WarmupLast = 7'(WARMUP_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoadKey,
        StLoadFrame,
        StWarmup,
        StRun
    } state_e;

    state_e               state_q;
    logic [6:0]           cnt_q;
    logic [6:0]           bit_cnt_q;
    logic [KEY_LEN-1:0]   key_q;
    logic [FRAME_LEN-1:0] frame_q;
    logic [6:0]           shreg_q;
    logic                 step_q;

    logic maj;
    logic step_ok;
    logic ks_bit;
    logic byte_done;

    assign maj       = (x_maj & y_maj) | (x_maj & z_maj) | (y_maj & z_maj);
    // No stepping while a completed byte is still waiting for downstream.
    assign step_ok   = !ks_valid || ks_ready;
    assign ks_bit    = x_out ^ y_out ^ z_out;
    assign byte_done = step_q && (bit_cnt_q == 7'd7);
    assign busy      = (state_q != StIdle);

    always_comb begin
        reg_clear = 1'b0;
        shift_bit = 1'b0;
        x_trigger = 1'b0;
        y_trigger = 1'b0;
        z_trigger = 1'b0;
        unique case (state_q)
            StClear: reg_clear = 1'b1;
            StLoadKey: begin
                shift_bit = key_q[0];
                x_trigger = step_ok;
                y_trigger = step_ok;
                z_trigger = step_ok;
            end
            StLoadFrame: begin
                shift_bit = frame_q[0];
                x_trigger = step_ok;
                y_trigger = step_ok;
                z_trigger = step_ok;
            end
            StWarmup, StRun: begin
                // A register steps when its clocking bit agrees with the majority.
                x_trigger = step_ok && (x_maj == maj);
                y_trigger = step_ok && (y_maj == maj);
                z_trigger = step_ok && (z_maj == maj);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            key_q     <= '0;
            frame_q   <= '0;
            shreg_q   <= '0;
            step_q    <= 1'b0;
            ks_byte   <= '0;
            ks_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q   <= key;
                        frame_q <= frame;
                        cnt_q   <= '0;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    cnt_q   <= '0;
                    state_q <= StLoadKey;
                end
                StLoadKey: begin
                    if (step_ok) begin
                        key_q <= key_q >> 1;
                        if (cnt_q == KeyLast) begin
                            cnt_q   <= '0;
                            state_q <= StLoadFrame;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                end
                StLoadFrame: begin
                    if (step_ok) begin
                        frame_q <= frame_q >> 1;
                        if (cnt_q == FrameLast) begin
                            cnt_q   <= '0;
                            state_q <= StWarmup;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                end
                StWarmup: begin
                    if (step_ok) begin
                        if (cnt_q == WarmupLast) begin
                            cnt_q   <= '0;
                            state_q <= StRun;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Register outputs settle one cycle after a step, so the capture lags by one.
            step_q <= (state_q == StRun) && step_ok && !stop;

            if (step_q) begin
                shreg_q   <= {shreg_q[5:0], ks_bit};
                bit_cnt_q <= byte_done ? 7'd0 : bit_cnt_q + 7'd1;
            end

            if (byte_done) begin
                ks_byte  <= {shreg_q, ks_bit};
                ks_valid <= 1'b1;
            end else if (ks_valid && ks_ready) begin
                ks_valid <= 1'b0;
            end

            // Leaving RUN throws away any partially assembled byte.
            if ((state_q == StRun) && stop) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end
        end
    end

endmodule
